// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module  : vga_sync_gen
// Brief   : VGA 640x480@60 timing generator with registered colour/sync/blank.
//           Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [7:0]  mVGA_RGB,
  output logic [10:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  output logic        pix_en,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic [7:0]  oVGA_RGB,
  output logic        sof
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [10:0] c_H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] c_H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] c_V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] c_VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_pix_en;
  logic [10:0]      r_h;
  logic [10:0]      r_v;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic [7:0]       r_rgb;
  logic             r_sof;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_wrap;
  logic             w_active;
  logic             w_hs_n;
  logic             w_vs_n;

  assign w_div_nxt = (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
  assign w_h_last  = (r_h == c_H_LAST);
  assign w_v_last  = (r_v == c_V_LAST);
  assign w_wrap    = r_pix_en && w_h_last && w_v_last;
  assign w_active  = (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_hs_n    = !((r_h >= c_HS_BEG) && (r_h <= c_HS_END));
  assign w_vs_n    = !((r_v >= c_VS_BEG) && (r_v <= c_VS_END));

  // pix_en is registered from the next divider value so it is high exactly
  // while r_div sits at its last count (and constantly high when CLK_DIV==1).
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_pix_en <= (w_div_nxt == c_DIV_LAST);
    end
  end

  // Stage-1 outputs are computed from the pre-increment counters, so they
  // lag oCoord by exactly one pixel tick.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_h       <= '0;
      r_v       <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
      r_sof     <= 1'b0;
    end else begin
      r_sof <= w_wrap;
      if (r_pix_en) begin
        r_h <= w_h_last ? '0 : r_h + 11'd1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 11'd1;
        end
        r_hs      <= w_hs_n;
        r_vs      <= w_vs_n;
        r_blank_n <= w_active;
        r_rgb     <= w_active ? mVGA_RGB : 8'h00;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_frame_cnt <= '0;
    end else if (w_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign oCoord_X     = r_h;
  assign oCoord_Y     = r_v;
  assign pix_en       = r_pix_en;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_BLANK_N = r_blank_n;
  assign oVGA_RGB     = r_rgb;
  assign sof          = r_sof;

endmodule

`default_nettype wire
